// File: rtl/seq_detect_101.sv
// Overlapping "101" serial detector with line-idle (zero-run) fault flag and a
// modulo-10 detection counter shown on an active-high 7-segment digit.
`timescale 1ns/1ps
module seq_detect_101 #(
    parameter int unsigned ZERO_RUN_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       detected,
    output logic       error,
    output logic [6:0] seg_out
);

    localparam int unsigned ZW    = $clog2(ZERO_RUN_MAX + 1);
    localparam int unsigned CW    = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ZW-1:0]     zero_run_q, zero_run_d;
    logic [CW-1:0]     count_q, count_d;
    logic              detected_q, detected_d;
    logic              error_q, error_d;
    logic [SEG_W-1:0]  seg_q, seg_d;

    // BCD digit to {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [CW-1:0] bcd);
        logic [SEG_W-1:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S0;
            zero_run_q <= '0;
            count_q    <= '0;
            detected_q <= 1'b0;
            error_q    <= 1'b0;
            seg_q      <= 7'b0111111;
        end else begin
            state_q    <= state_d;
            zero_run_q <= zero_run_d;
            count_q    <= count_d;
            detected_q <= detected_d;
            error_q    <= error_d;
            seg_q      <= seg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        zero_run_d = zero_run_q;
        count_d    = count_q;

        case (state_q)
            S0:      state_d = serial_in ? S1   : S0;
            S1:      state_d = serial_in ? S1   : S10;
            S10:     state_d = serial_in ? S101 : S0;
            S101:    state_d = serial_in ? S1   : S10;
            default: state_d = S0;
        endcase

        // Zero-run saturates so a long idle line holds the fault steady.
        if (serial_in) begin
            zero_run_d = '0;
        end else if (zero_run_q != ZW'(ZERO_RUN_MAX)) begin
            zero_run_d = zero_run_q + ZW'(1);
        end

        if (state_d == S101) begin
            count_d = (count_q == 4'd9) ? '0 : count_q + 4'd1;
        end

        // Outputs are computed from next-state values so they line up with the edge.
        detected_d = (state_d == S101);
        error_d    = (zero_run_d == ZW'(ZERO_RUN_MAX));
        seg_d      = seg_decode(count_d);
    end

    assign detected = detected_q;
    assign error    = error_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_seq_detect_101.sv
// Scoreboard bench for seq_detect_101: a history-based reference model pushes
// expected outputs per sampled bit; a monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_seq_detect_101;

    localparam int unsigned ZMAX = 3;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       detected;
    logic       error;
    logic [6:0] seg_out;

    typedef struct packed {
        logic       det;
        logic       err;
        logic [6:0] seg;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    bit         hist[$];
    int         zeros;
    int         cnt;
    logic [6:0] seg_tab[10];

    seq_detect_101 #(.ZERO_RUN_MAX(ZMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .detected  (detected),
        .error     (error),
        .seg_out   (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got det=%b err=%b seg=%b, want det=%b err=%b seg=%b",
                     name, got.det, got.err, got.seg, want.det, want.err, want.seg);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.det = 1'b0;
        e.err = 1'b0;
        e.seg = 7'b0111111;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t e;
        e.det = detected;
        e.err = error;
        e.seg = seg_out;
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        zeros = 0;
        cnt   = 0;
    endtask

    // Reference: match = last three samples since reset are 1,0,1; zeros = trailing-zero run.
    task automatic do_bit(input bit b);
        exp_t e;
        serial_in = b;
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
        e.det = (hist.size() == 3) && hist[0] && !hist[1] && hist[2];
        zeros = b ? 0 : ((zeros + 1 > ZMAX) ? ZMAX : zeros + 1);
        e.err = (zeros >= ZMAX);
        if (e.det) cnt = (cnt + 1) % 10;
        e.seg = seg_tab[cnt];
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input bit b);
        @(negedge clk);
        do_bit(b);
    endtask

    // Asynchronous assert just after an edge, check immediately, release on a negedge with first bit.
    task automatic async_reset(input bit first_bit);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", dut_out(), reset_exp());
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", dut_out(), reset_exp());
        rst = 1'b0;
        do_bit(first_bit);
    endtask

    // Monitor: every active cycle presents one output word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                exp_t w;
                w = exp_q.pop_front();
                check("scoreboard", dut_out(), w);
            end
        end
    end

    initial begin
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        model_reset();

        rst       = 1'b1;
        serial_in = 1'b0;
        #1;
        check("reset_initial", dut_out(), reset_exp());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_held", dut_out(), reset_exp());
        end
        @(negedge clk);
        rst = 1'b0;
        do_bit(1'b0);

        // Single match, then overlapping matches.
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        drive_bit(1'b0); drive_bit(1'b1);

        // Ten more overlapping matches: digit wraps through 9 to 0.
        for (int i = 0; i < 10; i++) begin
            drive_bit(1'b0); drive_bit(1'b1);
        end

        // Zero-run fault after reset: 0,1,0,0,0, more zeros, then a 1 clears it.
        async_reset(1'b0);
        drive_bit(1'b1);
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Count to 4, stop after "10", reset mid-pattern; a following 1 must not detect.
        async_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        end
        drive_bit(1'b1); drive_bit(1'b0);
        async_reset(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);

        // Random stream, mixing balanced and zero-heavy stretches, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit b;
            if ((i / 200) % 2 == 0) b = bit'($urandom_range(0, 1));
            else                    b = ($urandom_range(0, 99) < 30);
            if (i % 750 == 749) async_reset(b);
            else                drive_bit(b);
        end

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
